sd_fifo_sd_port: RTL and testbench
==================================

SD_FIFO_SD_PORT -- requirements
Module: sd_fifo_sd_port

Interface
REQ-001 The block SHALL have parameter BLK_LEN, default 512, bytes per block transfer (1..1024).
REQ-002 The block SHALL have parameter TIMEOUT, default 1024, stall-cycle limit for the watchdog (Configuration).
REQ-003 The block SHALL have one clock and an asynchronous active-low reset:
 sd_clk  in  1  sole clock, SD side of the FIFO bridge
 rst  in  1  asynchronous, active-low reset
 start_i  in  1  one-cycle transfer request, sampled in IDLE only
 dir_i  in  1  0 = transmit (FIFO to card), 1 = receive (card to FIFO)
 chan_i  in  1  0 = FIFO pair 1/2, 1 = FIFO pair 3/4
 busy_o  out  1  transfer in progress
 done_o  out  1  one-cycle completion pulse
 err_o  out  1  one-cycle abort pulse
 sd_adr_o  out  2  FIFO select to bridge SD port
 sd_dat_o  out  8  write data to bridge
 sd_dat_i  in  8  read data from bridge, valid one cycle after sd_re_o
 sd_we_o  out  1  FIFO write strobe
 sd_re_o  out  1  FIFO read strobe
 fifo_full  in  4  bridge full flags, index 1..4
 fifo_empty  in  4  bridge empty flags, index 1..4
 tx_dat_o  out  8  byte toward card line engine
 tx_valid_o  out  1  tx_dat_o valid
 tx_ready_i  in  1  line engine accepts byte
 rx_dat_i  in  8  byte from card line engine
 rx_valid_i  in  1  rx_dat_i valid
 rx_ready_o  out  1  block accepts rx byte

Function
REQ-004 FSM states SHALL be IDLE, TX, TX_DRAIN, RX, DONE; IDLE and start_i go to TX (dir_i=0) or RX (dir_i=1); dir_i/chan_i SHALL be latched at start.
REQ-005 sd_adr_o SHALL be {chan,dir}: TX reads FIFO 1 (adr 0) or 3 (adr 2); RX writes FIFO 2 (adr 1) or 4 (adr 3); sd_adr_o is held constant for the whole transfer.
REQ-006 TX: sd_re_o SHALL assert only when the selected fifo_empty bit is 0, issued-read count < BLK_LEN, and output-buffer occupancy plus in-flight reads < 2.
REQ-007 TX: sd_dat_i SHALL be captured into a 2-entry buffer the cycle after each sd_re_o; tx_valid_o SHALL be asserted whenever the buffer is non-empty; a byte is retired on tx_valid_o and tx_ready_i.
REQ-008 With tx_ready_i held high and the FIFO non-empty, TX throughput SHALL be one byte per cycle; the first tx_valid_o is asserted 2 cycles after entering TX.
REQ-009 TX: after BLK_LEN reads are issued, the FSM SHALL go to TX_DRAIN, stay there until BLK_LEN bytes are retired, then go to DONE.
REQ-010 RX: rx_ready_o SHALL equal (state==RX) and not the selected fifo_full bit; sd_we_o = rx_valid_i and rx_ready_o; sd_dat_o = rx_dat_i combinationally.
REQ-011 RX: after BLK_LEN accepted bytes the FSM SHALL go to DONE; bytes offered outside RX are not accepted.
REQ-012 DONE SHALL last one cycle, pulse done_o, and return to IDLE; busy_o = (state != IDLE).
REQ-013 The byte counters SHALL be 11 bits and terminal at BLK_LEN; no wrap-around within a transfer.
REQ-014 start_i outside IDLE SHALL be ignored; sd_we_o and sd_re_o SHALL never be high in the same cycle.

Reset
REQ-015 On rst low, the FSM SHALL enter IDLE; counters, buffer, busy_o, done_o, err_o, tx_valid_o, rx_ready_o, sd_we_o, sd_re_o SHALL be 0; sd_adr_o SHALL be 0.
REQ-016 Reset mid-transfer SHALL abort immediately with no done_o; buffered TX bytes are discarded.

Configuration
REQ-017 With SD_FIFO_SD_PORT_TIMEOUT_EN defined, a stall counter SHALL clear on every retired or accepted byte; at TIMEOUT consecutive stalled cycles in TX/TX_DRAIN/RX it SHALL pulse err_o, flush the buffer, and return to IDLE without done_o.
REQ-018 Without SD_FIFO_SD_PORT_TIMEOUT_EN, err_o SHALL be tied to 0, no stall counter SHALL exist, and the transfer SHALL wait indefinitely.

Verification
REQ-019 TX, chan 0, BLK_LEN=4, FIFO 1 holds 0x11..0x14, tx_ready_i=1 -> sd_adr_o=0, tx bytes 0x11,0x12,0x13,0x14 on consecutive cycles, then done_o one cycle later.
REQ-020 TX with tx_ready_i toggling 1/0 -> no byte lost or duplicated, at most 2 reads outstanding, sd_re_o never issued with fifo_empty[1]=1.
REQ-021 RX, chan 1, 4 bytes 0xA0..0xA3, fifo_full[4] forced high for 3 cycles mid-block -> sd_adr_o=3, rx_ready_o low during the stall, exactly 4 sd_we_o pulses, done_o.
REQ-022 rst low during TX after 2 bytes -> outputs at reset values next cycle, no done_o; new start_i after reset runs normally.
REQ-023 TIMEOUT_EN defined, TIMEOUT=8, TX with fifo_empty[3]=1 permanently -> err_o pulse after 8 cycles, busy_o low the following cycle.
REQ-024 start_i asserted in TX -> ignored; dir/chan unchanged until done_o.

Source files
------------

// File: rtl/sd_fifo_sd_port.sv
// sd_fifo_sd_port
// ---------------
// SD-side port of a FIFO bridge. It moves one block of BLK_LEN bytes
// between the bridge FIFOs and the card line engine.
//   transmit (dir=0): reads FIFO 1 or 3 and streams bytes to tx_*.
//   receive  (dir=1): accepts bytes from rx_* and writes FIFO 2 or 4.
//
// Handshake rules: a tx byte moves on any cycle where tx_valid_o && tx_ready_i.
// An rx byte moves on any cycle where rx_valid_i && rx_ready_o. Once valid
// is raised, the offering side holds both valid and data until the byte moves.
//
// Optional feature: define SD_FIFO_SD_PORT_TIMEOUT_EN to enable the stall
// watchdog. It aborts a transfer after TIMEOUT cycles with no progress and
// pulses err_o. Without the macro, err_o is tied low and the block waits
// indefinitely.
//
// Ports:
//   sd_clk, rst                clock, asynchronous active-low reset
//   start_i, dir_i, chan_i     transfer request, direction, FIFO pair select
//   busy_o, done_o, err_o      status, completion pulse, abort pulse
//   sd_adr_o                   FIFO select {chan,dir}
//   sd_dat_o/sd_we_o           FIFO write path
//   sd_dat_i/sd_re_o           FIFO read path; data arrives one cycle after read
//   fifo_full, fifo_empty      bridge flags; bit i belongs to FIFO i (1..4)
//   tx_dat_o/tx_valid_o/tx_ready_i   byte stream toward the card
//   rx_dat_i/rx_valid_i/rx_ready_o   byte stream from the card
//   dbg_state_o                current FSM state encoding
module sd_fifo_sd_port #(
    parameter int BLK_LEN = 512,
    parameter int TIMEOUT = 1024
) (
    input  logic       sd_clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       dir_i,
    input  logic       chan_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic [1:0] sd_adr_o,
    output logic [7:0] sd_dat_o,
    input  logic [7:0] sd_dat_i,
    output logic       sd_we_o,
    output logic       sd_re_o,
    input  logic [4:1] fifo_full,
    input  logic [4:1] fifo_empty,
    output logic [7:0] tx_dat_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    input  logic [7:0] rx_dat_i,
    input  logic       rx_valid_i,
    output logic       rx_ready_o,
    output logic [2:0] dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TX       = 3'd1,
        TX_DRAIN = 3'd2,
        RX       = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [10:0] BLK_CNT = 11'(BLK_LEN);

    state_t      state_q, state_d;
    logic [1:0]  adr_q, adr_d;
    logic [10:0] rd_cnt_q, rd_cnt_d;       // reads issued (transmit)
    logic [10:0] byte_cnt_q, byte_cnt_d;   // bytes retired (tx) or accepted (rx)
    logic        inflight_q, inflight_d;   // read issued last cycle, data on sd_dat_i now
    logic [7:0]  buf0_q, buf0_d;           // head of the output buffer
    logic [7:0]  buf1_q, buf1_d;
    logic [1:0]  occ_q, occ_d;             // output buffer occupancy 0..2

    logic        sel_full;
    logic        sel_empty;
    logic        pop;
    logic        push;
    logic        re;
    logic        rx_ready;
    logic        we;
    logic        abort;
    logic [2:0]  occ_net;

`ifdef SD_FIFO_SD_PORT_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);

    logic [STALL_W-1:0] stall_q, stall_d;
    logic               active;
`else
    // Watchdog is compiled out; keep the parameter referenced so the
    // configuration interface is identical in both builds.
    if (TIMEOUT < 1) begin : g_timeout_unused
    end
`endif

    // Flags of the FIFO addressed by the latched {chan,dir}.
    always_comb begin
        sel_full  = fifo_full[1];
        sel_empty = fifo_empty[1];
        case (adr_q)
            2'd0: begin sel_full = fifo_full[1]; sel_empty = fifo_empty[1]; end
            2'd1: begin sel_full = fifo_full[2]; sel_empty = fifo_empty[2]; end
            2'd2: begin sel_full = fifo_full[3]; sel_empty = fifo_empty[3]; end
            default: begin sel_full = fifo_full[4]; sel_empty = fifo_empty[4]; end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        rd_cnt_d   = rd_cnt_q;
        byte_cnt_d = byte_cnt_q;
        inflight_d = 1'b0;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        occ_d      = occ_q;
        abort      = 1'b0;
        err_o      = 1'b0;
`ifdef SD_FIFO_SD_PORT_TIMEOUT_EN
        stall_d    = stall_q;
        active     = 1'b0;
`endif

        // Transmit side. Occupancy is taken net of the byte leaving this
        // cycle so a steady stream sustains one read per cycle while the
        // buffer plus the in-flight read never exceed two entries.
        tx_valid_o = (occ_q != 2'd0);
        pop        = tx_valid_o && tx_ready_i;
        push       = inflight_q;
        occ_net    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

        // Receive side.
        rx_ready = (state_q == RX) && !sel_full;
        we       = rx_valid_i && rx_ready;

`ifdef SD_FIFO_SD_PORT_TIMEOUT_EN
        active = (state_q == TX) || (state_q == TX_DRAIN) || (state_q == RX);
        if (!active || pop || we) begin
            stall_d = '0;
        end else if (stall_q == STALL_LAST) begin
            stall_d = '0;
            abort   = 1'b1;
        end else begin
            stall_d = stall_q + 1'b1;
        end
        err_o = abort;
`endif

        // A read is never issued in an aborting cycle so no byte is pulled
        // from the FIFO only to be thrown away.
        re = (state_q == TX) && !sel_empty && (rd_cnt_q < BLK_CNT) &&
             (occ_net < 3'd2) && !abort;

        inflight_d = re;
        rd_cnt_d   = rd_cnt_q + {10'd0, re};
        byte_cnt_d = byte_cnt_q + {10'd0, (pop || we)};

        // Two-entry buffer, head in buf0.
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) buf0_d = sd_dat_i;
                else               buf1_d = sd_dat_i;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    buf0_d = sd_dat_i;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = sd_dat_i;
                end
            end
            default: ;
        endcase

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    adr_d      = {chan_i, dir_i};
                    rd_cnt_d   = 11'd0;
                    byte_cnt_d = 11'd0;
                    state_d    = dir_i ? RX : TX;
                end
            end
            TX: begin
                if (rd_cnt_d == BLK_CNT) state_d = TX_DRAIN;
            end
            TX_DRAIN: begin
                if (byte_cnt_d == BLK_CNT) state_d = DONE;
            end
            RX: begin
                if (byte_cnt_d == BLK_CNT) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d    = IDLE;
            occ_d      = 2'd0;
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge sd_clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            adr_q      <= 2'd0;
            rd_cnt_q   <= 11'd0;
            byte_cnt_q <= 11'd0;
            inflight_q <= 1'b0;
            buf0_q     <= 8'd0;
            buf1_q     <= 8'd0;
            occ_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            adr_q      <= adr_d;
            rd_cnt_q   <= rd_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            occ_q      <= occ_d;
        end
    end

`ifdef SD_FIFO_SD_PORT_TIMEOUT_EN
    always_ff @(posedge sd_clk or negedge rst) begin
        if (!rst) stall_q <= '0;
        else      stall_q <= stall_d;
    end
`endif

    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign sd_adr_o    = adr_q;
    assign sd_re_o     = re;
    assign sd_we_o     = we;
    assign sd_dat_o    = rx_dat_i;
    assign rx_ready_o  = rx_ready;
    assign tx_dat_o    = buf0_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sd_fifo_sd_port.sv
// Directed bench for sd_fifo_sd_port with BLK_LEN=4, TIMEOUT=8.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. A small bridge model returns read data one cycle after
// sd_re_o from tx_mem.
module tb_sd_fifo_sd_port;

  logic       sd_clk = 1'b0;
  logic       rst;
  logic       start_i, dir_i, chan_i;
  logic       busy_o, done_o, err_o;
  logic [1:0] sd_adr_o;
  logic [7:0] sd_dat_o, sd_dat_i;
  logic       sd_we_o, sd_re_o;
  logic [4:1] fifo_full, fifo_empty;
  logic [7:0] tx_dat_o;
  logic       tx_valid_o, tx_ready_i;
  logic [7:0] rx_dat_i;
  logic       rx_valid_i, rx_ready_o;
  logic [2:0] dbg_state_o;

  sd_fifo_sd_port #(.BLK_LEN(4), .TIMEOUT(8)) dut (
    .sd_clk(sd_clk), .rst(rst), .start_i(start_i), .dir_i(dir_i), .chan_i(chan_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .sd_adr_o(sd_adr_o),
    .sd_dat_o(sd_dat_o), .sd_dat_i(sd_dat_i), .sd_we_o(sd_we_o), .sd_re_o(sd_re_o),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .tx_dat_o(tx_dat_o),
    .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i), .rx_dat_i(rx_dat_i),
    .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o), .dbg_state_o(dbg_state_o)
  );

  // clock / watchdog
  always #5 sd_clk = ~sd_clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed no_finish expected finish");
    $fatal(1, "bench timed out");
  end

  int checks = 0;
  int errors = 0;

  logic [7:0] tx_mem [0:31];
  int         tx_ptr = 0;
  logic       bridge_req;

  logic [7:0] got_q [$];
  logic [7:0] wr_q [$];
  int done_cnt = 0, err_cnt = 0, re_empty_viol = 0, both_viol = 0;
  int outstanding = 0, max_out = 0;
  int exp_sel = 1;   // FIFO index (1..4) the current transfer should use

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sd_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge sd_clk);
  endtask

  // Request is raised in cycle S; the FSM is in its first working cycle
  // when this returns.
  task automatic start_xfer(input logic d, input logic c);
    tick();
    start_i = 1'b1;
    dir_i   = d;
    chan_i  = c;
    tick();
    start_i = 1'b0;
  endtask

  // bridge model: data valid the cycle after a read strobe
  initial forever begin
    @(negedge sd_clk);
    bridge_req = sd_re_o && rst;
    @(posedge sd_clk);
    #1;
    if (bridge_req) begin
      sd_dat_i = tx_mem[tx_ptr];
      tx_ptr++;
    end
  end

  // monitor
  initial forever begin
    @(negedge sd_clk);
    if (!rst) begin
      outstanding = 0;
    end else begin
      if (tx_valid_o && tx_ready_i) begin
        got_q.push_back(tx_dat_o);
        outstanding--;
      end
      if (sd_re_o) outstanding++;
      if (outstanding > max_out) max_out = outstanding;
      if (sd_we_o) wr_q.push_back(sd_dat_o);
      if (done_o) done_cnt++;
      if (err_o) err_cnt++;
      if (sd_re_o && fifo_empty[exp_sel]) re_empty_viol++;
      if (sd_re_o && sd_we_o) both_viol++;
    end
  end

  int  d0, e0, idx, adr_bad, early;
  logic got_done;
  logic [7:0] v;

  initial begin
    rst = 1'b0; start_i = 1'b0; dir_i = 1'b0; chan_i = 1'b0; sd_dat_i = 8'h00;
    fifo_full = 4'h0; fifo_empty = 4'hF; tx_ready_i = 1'b0;
    rx_dat_i = 8'h00; rx_valid_i = 1'b0;
    for (int i = 0; i < 32; i++) tx_mem[i] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tx_mem[i]      = 8'(8'h11 + i);
      tx_mem[4 + i]  = 8'(8'h21 + i);
      tx_mem[11 + i] = 8'(8'h41 + i);
    end
    for (int i = 0; i < 3; i++) tx_mem[8 + i] = 8'(8'h31 + i);

    // ---- reset state
    sample();
    sample();
    check("rst_busy", 16'(busy_o), 16'h0);
    check("rst_done", 16'(done_o), 16'h0);
    check("rst_err", 16'(err_o), 16'h0);
    check("rst_tx_valid", 16'(tx_valid_o), 16'h0);
    check("rst_rx_ready", 16'(rx_ready_o), 16'h0);
    check("rst_we", 16'(sd_we_o), 16'h0);
    check("rst_re", 16'(sd_re_o), 16'h0);
    check("rst_adr", 16'(sd_adr_o), 16'h0);
    check("rst_state", 16'(dbg_state_o), 16'h0);
    tick();
    rst = 1'b1;

    // ---- transmit chan 0, ready held high: one byte per cycle
    tick();
    fifo_empty = 4'b1110;
    tx_ready_i = 1'b1;
    exp_sel = 1;
    start_xfer(1'b0, 1'b0);
    sample();
    check("tx_c0_re", 16'(sd_re_o), 16'h1);
    check("tx_c0_adr", 16'(sd_adr_o), 16'h0);
    check("tx_c0_busy", 16'(busy_o), 16'h1);
    check("tx_c0_valid", 16'(tx_valid_o), 16'h0);
    tick();
    sample();
    check("tx_c1_valid", 16'(tx_valid_o), 16'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      sample();
      check("tx_stream_valid", 16'(tx_valid_o), 16'h1);
      check("tx_stream_dat", 16'(tx_dat_o), 16'(8'h11 + i));
    end
    tick();
    sample();
    check("tx_done_pulse", 16'(done_o), 16'h1);
    tick();
    sample();
    check("tx_done_end", 16'(done_o), 16'h0);
    check("tx_idle_busy", 16'(busy_o), 16'h0);

    // ---- transmit with ready toggling, FIFO empty flickering, start ignored
    got_q.delete();
    d0 = done_cnt;
    tx_ready_i = 1'b0;
    start_xfer(1'b0, 1'b0);
    adr_bad = 0;
    got_done = 1'b0;
    for (int c = 0; c < 60 && !got_done; c++) begin
      sample();
      if (sd_adr_o !== 2'd0) adr_bad++;
      if (done_o) got_done = 1'b1;
      tick();
      tx_ready_i    = (c % 2 == 0);
      fifo_empty[1] = (c % 3 == 1);
      start_i       = (c == 3);
      dir_i         = (c == 3);
      chan_i        = (c == 3);
    end
    start_i = 1'b0; dir_i = 1'b0; chan_i = 1'b0; fifo_empty = 4'hF; tx_ready_i = 1'b0;
    sample();
    check("tog_done_seen", 16'(got_done), 16'h1);
    check("tog_idle_after", 16'(busy_o), 16'h0);
    check("tog_count", 16'(got_q.size()), 16'h4);
    for (int i = 0; i < 4; i++) begin
      v = (i < got_q.size()) ? got_q[i] : 8'hxx;
      check("tog_byte", 16'(v), 16'(8'h21 + i));
    end
    check("tog_done_once", 16'(done_cnt - d0), 16'h1);
    check("tog_adr_stable", 16'(adr_bad), 16'h0);
    check("tog_re_empty", 16'(re_empty_viol), 16'h0);
    check("tog_max_out", 16'(max_out <= 2), 16'h1);
    check("tog_no_we", 16'(wr_q.size()), 16'h0);

    // ---- receive chan 1, FIFO 4 full for 3 cycles mid-block
    tick();
    wr_q.delete();
    d0 = done_cnt;
    idx = 0;
    exp_sel = 4;
    start_xfer(1'b1, 1'b1);
    got_done = 1'b0;
    for (int c = 0; c < 30 && !got_done; c++) begin
      rx_valid_i   = (idx < 4);
      rx_dat_i     = 8'(8'hA0 + idx);
      fifo_full[4] = (c >= 2 && c <= 4);
      sample();
      if (c == 0) check("rx_adr", 16'(sd_adr_o), 16'h3);
      if (c >= 2 && c <= 4) check("rx_stall_ready", 16'(rx_ready_o), 16'h0);
      if (rx_valid_i && rx_ready_o) idx++;
      if (done_o) got_done = 1'b1;
      tick();
    end
    rx_valid_i = 1'b0;
    fifo_full = 4'h0;
    sample();
    check("rx_done_seen", 16'(got_done), 16'h1);
    check("rx_we_count", 16'(wr_q.size()), 16'h4);
    for (int i = 0; i < 4; i++) begin
      v = (i < wr_q.size()) ? wr_q[i] : 8'hxx;
      check("rx_byte", 16'(v), 16'(8'hA0 + i));
    end
    check("rx_done_once", 16'(done_cnt - d0), 16'h1);
    check("rx_both_strobes", 16'(both_viol), 16'h0);

    // ---- reset in the middle of a chan 1 transmit, after two bytes
    tick();
    got_q.delete();
    d0 = done_cnt;
    fifo_empty = 4'b1011;
    tx_ready_i = 1'b1;
    exp_sel = 3;
    start_xfer(1'b0, 1'b1);
    sample();
    check("rst_tx_adr", 16'(sd_adr_o), 16'h2);
    tick();
    sample();
    tick();
    sample();
    check("rst_tx_b0", 16'(tx_dat_o), 16'h31);
    tick();
    fifo_empty = 4'hF;
    sample();
    check("rst_tx_b1", 16'(tx_dat_o), 16'h32);
    check("rst_tx_busy", 16'(busy_o), 16'h1);
    tick();
    rst = 1'b0;
    sample();
    check("mid_rst_busy", 16'(busy_o), 16'h0);
    check("mid_rst_valid", 16'(tx_valid_o), 16'h0);
    check("mid_rst_re", 16'(sd_re_o), 16'h0);
    check("mid_rst_adr", 16'(sd_adr_o), 16'h0);
    check("mid_rst_done", 16'(done_o), 16'h0);
    tick();
    rst = 1'b1;
    tick();
    sample();
    check("mid_rst_no_done", 16'(done_cnt - d0), 16'h0);
    check("mid_rst_bytes", 16'(got_q.size()), 16'h2);

    // transfer after the reset runs normally
    got_q.delete();
    d0 = done_cnt;
    fifo_empty = 4'b1110;
    exp_sel = 1;
    start_xfer(1'b0, 1'b0);
    got_done = 1'b0;
    for (int c = 0; c < 30 && !got_done; c++) begin
      sample();
      if (done_o) got_done = 1'b1;
      tick();
    end
    fifo_empty = 4'hF;
    sample();
    check("post_rst_done", 16'(got_done), 16'h1);
    check("post_rst_count", 16'(got_q.size()), 16'h4);
    for (int i = 0; i < 4; i++) begin
      v = (i < got_q.size()) ? got_q[i] : 8'hxx;
      check("post_rst_byte", 16'(v), 16'(8'h41 + i));
    end

    // ---- transmit from a permanently empty FIFO 3
    tick();
    d0 = done_cnt;
    e0 = err_cnt;
    exp_sel = 3;
    fifo_empty = 4'hF;
    start_xfer(1'b0, 1'b1);
`ifdef SD_FIFO_SD_PORT_TIMEOUT_EN
    early = 0;
    for (int k = 0; k < 7; k++) begin
      sample();
      if (err_o) early++;
      tick();
    end
    sample();
    check("to_err_pulse", 16'(err_o), 16'h1);
    check("to_no_early_err", 16'(early), 16'h0);
    tick();
    sample();
    check("to_busy_low", 16'(busy_o), 16'h0);
    check("to_err_end", 16'(err_o), 16'h0);
    check("to_no_done", 16'(done_cnt - d0), 16'h0);
`else
    for (int k = 0; k < 20; k++) begin
      sample();
      tick();
    end
    sample();
    check("stall_busy", 16'(busy_o), 16'h1);
    check("stall_state", 16'(dbg_state_o), 16'h1);
    check("stall_no_err", 16'(err_cnt - e0), 16'h0);
    check("stall_no_re", 16'(sd_re_o), 16'h0);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
